row_clear_scan: RTL and testbench

- Board-side reader/compactor for the token matrix.
- The token writer places token rows at addresses 0..2 (top) via an address/row-data bus; this block is the other end of that bus.
- It reads every board row back, detects full rows (all COLS bits set), and rewrites the board with surviving rows shifted toward the bottom and zero rows at the top.
- It is started by the game controller after a token lands, and reports the number of cleared lines.

---
 rtl/board_pkg.sv | 22 ++
 rtl/row_clear_scan.sv | 133 +++++++++++++
 tb/tb_row_clear_scan.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/board_pkg.sv
// Shared geometry and scanner state encoding for the token matrix board.
// The token writer uses the same row and address types on its side of the bus.
package board_pkg;

    localparam int BOARD_ROWS   = 20;
    localparam int BOARD_COLS   = 10;
    localparam int BOARD_ADDR_W = 5;

    typedef logic [BOARD_COLS-1:0]   row_t;
    typedef logic [BOARD_ADDR_W-1:0] addr_t;

    typedef enum logic [2:0] {
        IDLE,
        RD_REQ,
        RD_CAP,
        WR,
        CLR_CHK,
        CLR,
        DONE
    } scan_state_t;

endpackage

// File: rtl/row_clear_scan.sv
// Scans the board bottom-up, drops full rows, shifts survivors down and
// zero-fills the top, then reports how many lines were cleared.
module row_clear_scan
    import board_pkg::*;
#(
    parameter int ROWS   = BOARD_ROWS,
    parameter int COLS   = BOARD_COLS,
    parameter int ADDR_W = BOARD_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [COLS-1:0]   bus_data_i,
    output logic [ADDR_W-1:0] address,
    output logic [COLS-1:0]   bus_data_o,
    output logic              we,
    output logic              busy,
    output logic              done,
    output logic [4:0]        lines_cleared
);

    localparam logic [ADDR_W-1:0] LAST_ROW = ADDR_W'(ROWS - 1);
    localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);
    localparam logic [4:0]        CNT_ONE  = 5'd1;

    scan_state_t       state;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W-1:0] wr_ptr;
    logic [COLS-1:0]   row_q;
    logic [4:0]        count;
    logic [4:0]        lines_q;

    logic       row_full;
    logic [4:0] count_inc;

    assign row_full  = &bus_data_i;
    assign count_inc = count + CNT_ONE;

    // The zero-fill check is folded into the last scan transition so it
    // costs no cycle: any owed rows go straight to CLR, otherwise to DONE.
    function automatic scan_state_t after_scan(input logic [4:0] owed);
        return (owed != 5'd0) ? CLR : DONE;
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            rd_ptr  <= LAST_ROW;
            wr_ptr  <= LAST_ROW;
            row_q   <= '0;
            count   <= '0;
            lines_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        rd_ptr <= LAST_ROW;
                        wr_ptr <= LAST_ROW;
                        count  <= '0;
                        state  <= RD_REQ;
                    end
                end
                RD_REQ: state <= RD_CAP;
                RD_CAP: begin
                    row_q <= bus_data_i;
                    if (!row_full && (wr_ptr != rd_ptr)) begin
                        state <= WR;
                    end else begin
                        if (row_full) begin
                            count <= count_inc;
                        end else if (rd_ptr != '0) begin
                            wr_ptr <= wr_ptr - PTR_ONE;
                        end
                        if (rd_ptr == '0) begin
                            state <= after_scan(row_full ? count_inc : count);
                        end else begin
                            rd_ptr <= rd_ptr - PTR_ONE;
                            state  <= RD_REQ;
                        end
                    end
                end
                WR: begin
                    // A moving row always lands strictly below the read pointer,
                    // so wr_ptr is at least 1 here.
                    wr_ptr <= wr_ptr - PTR_ONE;
                    if (rd_ptr == '0) begin
                        state <= after_scan(count);
                    end else begin
                        rd_ptr <= rd_ptr - PTR_ONE;
                        state  <= RD_REQ;
                    end
                end
                CLR_CHK: state <= after_scan(count);
                CLR: begin
                    if (wr_ptr == '0) begin
                        state <= DONE;
                    end else begin
                        wr_ptr <= wr_ptr - PTR_ONE;
                    end
                end
                DONE: begin
                    lines_q <= count;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        address    = '0;
        bus_data_o = '0;
        we         = 1'b0;
        case (state)
            RD_REQ: address = rd_ptr;
            WR: begin
                address    = wr_ptr;
                bus_data_o = row_q;
                we         = 1'b1;
            end
            CLR: begin
                address = wr_ptr;
                we      = 1'b1;
            end
            default: ;
        endcase
    end

    assign busy          = (state != IDLE);
    assign done          = (state == DONE);
    assign lines_cleared = lines_q;

endmodule

// File: tb/tb_row_clear_scan.sv
// Bench for row_clear_scan: a 1-cycle-read board RAM, a table of board
// images with expected results, and hand-written restart/reset sequences.
module tb_row_clear_scan;

    localparam int ROWS   = 20;
    localparam int COLS   = 10;
    localparam int ADDR_W = 5;
    localparam int BITS   = ROWS * COLS;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [COLS-1:0]   bus_data_i;
    logic [ADDR_W-1:0] address;
    logic [COLS-1:0]   bus_data_o;
    logic              we;
    logic              busy;
    logic              done;
    logic [4:0]        lines_cleared;

    always #5 clk = ~clk;

    row_clear_scan #(.ROWS(ROWS), .COLS(COLS), .ADDR_W(ADDR_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .bus_data_i   (bus_data_i),
        .address      (address),
        .bus_data_o   (bus_data_o),
        .we           (we),
        .busy         (busy),
        .done         (done),
        .lines_cleared(lines_cleared)
    );

    // Board RAM; the bench takes over the port to load and inspect it while idle.
    logic [COLS-1:0]   mem [32];
    logic              tb_sel;
    logic              tb_we;
    logic [ADDR_W-1:0] tb_addr;
    logic [COLS-1:0]   tb_data;
    logic [ADDR_W-1:0] m_addr;
    logic              m_we;
    logic [COLS-1:0]   m_wdata;

    assign m_addr  = tb_sel ? tb_addr : address;
    assign m_we    = tb_sel ? tb_we : we;
    assign m_wdata = tb_sel ? tb_data : bus_data_o;

    always @(posedge clk) begin
        if (m_we) mem[m_addr] <= m_wdata;
        bus_data_i <= mem[m_addr];
    end

    typedef struct packed {
        logic [BITS-1:0] init;
        logic [BITS-1:0] exp_b;
        logic [4:0]      lines;
        logic [7:0]      cyc;
        logic [7:0]      writes;
    } vec_t;

    int passed = 0;
    int total  = 0;

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act == req) passed++;
        else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, req, req);
    endtask

    function automatic logic [BITS-1:0] put(input logic [BITS-1:0] b, input int r,
                                             input logic [COLS-1:0] v);
        logic [BITS-1:0] t;
        t = b;
        t[r*COLS +: COLS] = v;
        return t;
    endfunction

    task automatic load_board(input logic [BITS-1:0] b);
        @(negedge clk);
        tb_sel = 1'b1;
        tb_we  = 1'b1;
        for (int r = 0; r < ROWS; r++) begin
            tb_addr = ADDR_W'(r);
            tb_data = b[r*COLS +: COLS];
            @(negedge clk);
        end
        tb_we  = 1'b0;
        tb_sel = 1'b0;
    endtask

    task automatic check_board(input logic [BITS-1:0] e, input string tag);
        @(negedge clk);
        tb_sel = 1'b1;
        tb_we  = 1'b0;
        for (int r = 0; r < ROWS; r++) begin
            tb_addr = ADDR_W'(r);
            @(negedge clk);
            check($sformatf("%s row%0d", tag, r), int'(bus_data_i), int'(e[r*COLS +: COLS]));
        end
        tb_sel = 1'b0;
    endtask

    // Cycle 1 is the cycle right after start is sampled; cyc ends on the done cycle.
    task automatic run_scan(input int restart_at, output int cyc, output int writes,
                            output int dones, output int rd_bad);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start  = 1'b0;
        cyc    = 1;
        writes = 0;
        dones  = 0;
        rd_bad = 0;
        while (cyc < 300) begin
            if (we) writes++;
            if ((cyc % 2 == 1) && (cyc <= 2*ROWS) && (int'(address) != ROWS - 1 - (cyc - 1)/2))
                rd_bad++;
            if (done) begin
                dones++;
                break;
            end
            start = (cyc == restart_at);
            @(posedge clk);
            #1;
            cyc++;
        end
        start = 1'b0;
    endtask

    vec_t            vecs [6];
    logic [BITS-1:0] b;
    logic [BITS-1:0] full_b;
    int              cyc, writes, dones, rd_bad, extra;

    initial begin
        reset   = 1'b1;
        start   = 1'b1;
        tb_sel  = 1'b0;
        tb_we   = 1'b0;
        tb_addr = '0;
        tb_data = '0;

        full_b = '0;
        for (int r = 0; r < ROWS; r++) full_b = put(full_b, r, 10'h3FF);

        // empty board
        vecs[0] = '{init: '0, exp_b: '0, lines: 5'd0, cyc: 8'd41, writes: 8'd0};
        // one cleared line at the bottom
        b = put('0, 19, 10'h3FF);
        b = put(b, 18, 10'h030);
        vecs[1] = '{init: b, exp_b: put('0, 19, 10'h030), lines: 5'd1, cyc: 8'd61, writes: 8'd20};
        // two interleaved full rows
        b = put('0, 19, 10'h3FF);
        b = put(b, 18, 10'h001);
        b = put(b, 17, 10'h3FF);
        b = put(b, 16, 10'h070);
        vecs[2] = '{init: b, exp_b: put(put('0, 19, 10'h001), 18, 10'h070),
                    lines: 5'd2, cyc: 8'd61, writes: 8'd20};
        // whole board full
        vecs[3] = '{init: full_b, exp_b: '0, lines: 5'd20, cyc: 8'd61, writes: 8'd20};
        // only the top row full
        b = put('0, 0, 10'h3FF);
        b = put(b, 5, 10'h155);
        vecs[4] = '{init: b, exp_b: put('0, 5, 10'h155), lines: 5'd1, cyc: 8'd42, writes: 8'd1};
        // full row in the middle with rows above and below it
        b = put('0, 12, 10'h2AA);
        b = put(b, 10, 10'h3FF);
        b = put(b, 9, 10'h123);
        b = put(b, 0, 10'h001);
        vecs[5] = '{init: b, exp_b: put(put(put('0, 12, 10'h2AA), 10, 10'h123), 1, 10'h001),
                    lines: 5'd1, cyc: 8'd52, writes: 8'd11};

        // start held together with reset must not begin a scan
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        start = 1'b0;
        @(posedge clk);
        #1;
        check("reset busy", int'(busy), 0);
        check("reset done", int'(done), 0);
        check("reset we", int'(we), 0);
        check("reset address", int'(address), 0);
        check("reset data_o", int'(bus_data_o), 0);
        check("reset lines", int'(lines_cleared), 0);

        for (int i = 0; i < 6; i++) begin
            load_board(vecs[i].init);
            run_scan(-1, cyc, writes, dones, rd_bad);
            check($sformatf("v%0d done cycle", i), cyc, int'(vecs[i].cyc));
            check($sformatf("v%0d writes", i), writes, int'(vecs[i].writes));
            if (i == 0) check("v0 read order", rd_bad, 0);
            @(posedge clk);
            #1;
            check($sformatf("v%0d done pulse", i), int'(done), 0);
            check($sformatf("v%0d busy after", i), int'(busy), 0);
            check($sformatf("v%0d lines", i), int'(lines_cleared), int'(vecs[i].lines));
            check_board(vecs[i].exp_b, $sformatf("v%0d", i));
        end

        // start re-pulsed mid-scan is ignored
        load_board(vecs[1].init);
        run_scan(7, cyc, writes, dones, rd_bad);
        check("restart done cycle", cyc, 61);
        extra = 0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk);
            #1;
            if (done || busy) extra++;
        end
        check("restart extra activity", extra, 0);
        check("restart lines", int'(lines_cleared), 1);
        check_board(vecs[1].exp_b, "restart");

        // reset during the 10th scan cycle
        load_board(full_b);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        cyc = 1;
        while (cyc < 10) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check("midscan busy before", int'(busy), 1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("midscan busy", int'(busy), 0);
        check("midscan we", int'(we), 0);
        check("midscan address", int'(address), 0);
        check("midscan lines", int'(lines_cleared), 0);
        check("midscan done", int'(done), 0);
        run_scan(-1, cyc, writes, dones, rd_bad);
        check("rescan done cycle", cyc, 61);
        check("rescan writes", writes, 20);
        @(posedge clk);
        #1;
        check("rescan lines", int'(lines_cleared), 20);
        check_board('0, "rescan");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
